// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the most-negative two's-complement constant.
package divider32_seq_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/divider32_seq_if.sv
// Start/done handshake, operands and results of the sequential divider.
interface divider32_seq_if import divider32_seq_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SIGNED;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DZ;
    logic             V;

    modport master (
        output start, A, B, SIGNED,
        input  busy, done, Q, R, DZ, V
    );

    modport slave (
        input  start, A, B, SIGNED,
        output busy, done, Q, R, DZ, V
    );
endinterface

// File: rtl/divider32_seq_div_step.sv
// One restoring-division iteration: shift {P, D} left, trial-subtract the
// divisor magnitude and keep the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] d_o
);
    // One guard bit above the (WIDTH+1)-bit partial remainder carries the
    // borrow, so the trial result's sign is a single bit.
    logic [WIDTH+1:0] p_shift;
    logic [WIDTH+1:0] trial;

    assign p_shift = {p_i, d_i[WIDTH-1]};
    assign trial   = p_shift - {2'b00, b_i};

    // Restore on borrow, otherwise accept the difference and shift in a 1.
    always_comb begin
        p_o = p_shift[WIDTH:0];
        d_o = {d_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            p_o = trial[WIDTH:0];
            d_o = {d_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/divider32_seq.sv
// Iterative signed/unsigned divider: one restoring step per clock on operand
// magnitudes, sign correction in a final FIX cycle, start/done handshake.
module divider32_seq import divider32_seq_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic          clk,
    input logic          rst,
    divider32_seq_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_V     = WIDTH'(1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH:0]   p_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] b_mag_q;
    logic [WIDTH-1:0] a_orig_q;
    logic             sgn_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dz_q;
    logic             v_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Operand magnitudes; only negative operands in signed mode are negated.
    assign a_neg = bus.SIGNED & bus.A[WIDTH-1];
    assign b_neg = bus.SIGNED & bus.B[WIDTH-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .d_i (d_q),
        .b_i (b_mag_q),
        .p_o (p_d),
        .d_o (d_d)
    );

    // Sequencer: capture, WIDTH iterations, sign fix-up, one-cycle done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            d_q      <= '0;
            b_mag_q  <= '0;
            a_orig_q <= '0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            q_q      <= '0;
            r_q      <= '0;
            dz_q     <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        cnt_q    <= '0;
                        p_q      <= '0;
                        d_q      <= a_mag;
                        b_mag_q  <= b_mag;
                        a_orig_q <= bus.A;
                        sgn_q    <= bus.SIGNED;
                        neg_a_q  <= a_neg;
                        neg_b_q  <= b_neg;
                        dz_q     <= 1'b0;
                        v_q      <= 1'b0;
                        busy_q   <= 1'b1;
                        // A zero divisor skips the iterations entirely.
                        state_q  <= (bus.B == '0) ? S_FIX : S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    p_q   <= p_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                    if (b_mag_q == '0) begin
                        q_q  <= '1;
                        r_q  <= a_orig_q;
                        dz_q <= 1'b1;
                        v_q  <= 1'b0;
                    end else begin
                        q_q  <= (sgn_q & (neg_a_q ^ neg_b_q)) ? -d_q : d_q;
                        r_q  <= (sgn_q & neg_a_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                        // MIN / -1: the magnitude path already yields Q=MIN, R=0.
                        v_q  <= sgn_q & (a_orig_q == MIN_V) & neg_b_q & (b_mag_q == ONE_V);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.DZ   = dz_q;
    assign bus.V    = v_q;
endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: latency-level reference model with a
// per-cycle output compare, directed scenarios pinned by literals, and random
// operations with start noise while busy.
module tb_divider32_seq;
    import divider32_seq_pkg::*;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        v;
    } res_t;

    logic clk;
    logic rst;

    divider32_seq_if #(.WIDTH(32)) bus ();

    divider32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Arithmetic reference derived from the division rules.
    function automatic res_t ref_div(logic [31:0] a, logic [31:0] b, logic s);
        res_t res;
        int   sa;
        int   sb;
        res = '0;
        if (b == 32'd0) begin
            res.q  = 32'hFFFF_FFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else if (!s) begin
            res.q = a / b;
            res.r = a % b;
        end else if (a == DIV_MIN && b == 32'hFFFF_FFFF) begin
            res.q = DIV_MIN;
            res.r = 32'd0;
            res.v = 1'b1;
        end else begin
            sa    = $signed(a);
            sb    = $signed(b);
            res.q = 32'(sa / sb);
            res.r = 32'(sa % sb);
        end
        return res;
    endfunction

    // Timing model: an accepted operation completes a fixed number of edges
    // later (33, or 1 for a zero divisor); start is only honoured when no
    // operation is in flight.
    bit          m_active;
    int          m_left;
    res_t        m_pend;
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic        m_dz;
    logic        m_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_left   <= 0;
            m_pend   <= '0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_q      <= '0;
            m_r      <= '0;
            m_dz     <= 1'b0;
            m_v      <= 1'b0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_active <= 1'b1;
                m_pend   <= ref_div(bus.A, bus.B, bus.SIGNED);
                m_left   <= (bus.B == 32'd0) ? 1 : 33;
                m_busy   <= 1'b1;
                m_dz     <= 1'b0;
                m_v      <= 1'b0;
            end
        end else if (m_left == 1) begin
            m_active <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b1;
            m_q      <= m_pend.q;
            m_r      <= m_pend.r;
            m_dz     <= m_pend.dz;
            m_v      <= m_pend.v;
        end else begin
            m_left <= m_left - 1;
        end
    end

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                vectors++;
                if (bus.busy !== m_busy || bus.done !== m_done || bus.Q !== m_q ||
                    bus.R !== m_r || bus.DZ !== m_dz || bus.V !== m_v) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t got busy=%b done=%b Q=%08h R=%08h DZ=%b V=%b want busy=%b done=%b Q=%08h R=%08h DZ=%b V=%b",
                             $time, bus.busy, bus.done, bus.Q, bus.R, bus.DZ, bus.V,
                             m_busy, m_done, m_q, m_r, m_dz, m_v);
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_start(logic [31:0] a, logic [31:0] b, logic s, bit hold);
        bus.A      = a;
        bus.B      = b;
        bus.SIGNED = s;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) break;
            if (n >= 100) begin
                vectors++;
                miscompares++;
                $display("FAIL done-timeout: got no done after %0d cycles, expected done", n);
                break;
            end
        end
    endtask

    task automatic chk_res(string name, logic [31:0] q, logic [31:0] r, logic dz, logic v);
        chk({name, ".Q"}, bus.Q, q);
        chk({name, ".R"}, bus.R, r);
        chk({name, ".DZ"}, 32'(bus.DZ), 32'(dz));
        chk({name, ".V"}, 32'(bus.V), 32'(v));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] x;
        case ($urandom_range(0, 5))
            0:       x = $urandom;
            1:       x = 32'($urandom_range(0, 20));
            2:       x = 32'd0;
            3:       x = DIV_MIN;
            4:       x = 32'hFFFF_FFFF;
            default: x = $urandom >> $urandom_range(0, 31);
        endcase
        return x;
    endfunction

    initial begin
        int   n;
        res_t pin;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.SIGNED = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Reset state.
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk_res("reset", 32'd0, 32'd0, 1'b0, 1'b0);

        // Pin the reference model against hand-computed values.
        pin = ref_div(32'd100, 32'd7, 1'b0);
        chk("model.100/7.Q", pin.q, 32'h0000_000E);
        chk("model.100/7.R", pin.r, 32'h0000_0002);
        pin = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("model.-7/2.Q", pin.q, 32'hFFFF_FFFD);
        chk("model.-7/2.R", pin.r, 32'hFFFF_FFFF);

        // Unsigned 100 / 7.
        do_start(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(n);
        chk("u100/7.latency", 32'(n), 32'd33);
        chk_res("u100/7", 32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0);

        // Signed -7 / 2.
        do_start(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        wait_done(n);
        chk_res("s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Divide by zero, both modes.
        do_start(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        wait_done(n);
        chk("dz.u.latency", 32'(n), 32'd1);
        chk_res("dz.u", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        do_start(32'h1234_5678, 32'd0, 1'b1, 1'b0);
        wait_done(n);
        chk("dz.s.latency", 32'(n), 32'd1);
        chk_res("dz.s", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);

        // MIN / -1 signed then unsigned.
        do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done(n);
        chk_res("min/-1.s", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done(n);
        chk_res("min/-1.u", 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Start while busy is ignored.
        do_start(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        do_start(32'h0000_1234, 32'd3, 1'b1, 1'b0);
        wait_done(n);
        chk("ignore.latency", 32'(n), 32'd23);
        chk_res("ignore", 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0);

        // Reset in the middle of a run.
        do_start(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk_res("midrst", 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("postrst.Q", bus.Q, 32'd0);

        // Back-to-back with start held through DONE.
        do_start(32'h64, 32'h0A, 1'b0, 1'b1);
        wait_done(n);
        chk("b2b.first.latency", 32'(n), 32'd33);
        chk_res("b2b.first", 32'hA, 32'h0, 1'b0, 1'b0);
        bus.A = 32'h65;
        wait_done(n);
        chk("b2b.spacing", 32'(n), 32'd34);
        chk_res("b2b.second", 32'hA, 32'h1, 1'b0, 1'b0);
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        // Random operations, noisy start while busy, random gaps.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.start = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            do_start(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'b0);
            n = 0;
            while (1) begin
                @(posedge clk);
                #1;
                n++;
                if (bus.done === 1'b1) break;
                if (n >= 100) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rand-timeout: got no done after %0d cycles, expected done", n);
                    break;
                end
                bus.start  = ($urandom_range(0, 3) == 0);
                bus.A      = $urandom;
                bus.B      = $urandom;
                bus.SIGNED = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
